// File: rtl/preemption_watchdog.sv
// Instruction-quantum preemption timer: counts user-space commits down from a quantum and
// raises a context-exchange request on expiry. Optional macro: WATCHDOG_AUTO_REARM_EN.
module preemption_watchdog #(
    parameter int                       QUANTUM_WIDTH   = 32,
    parameter logic [QUANTUM_WIDTH-1:0] DEFAULT_QUANTUM = QUANTUM_WIDTH'(1000),
    parameter logic [11:0]              OS_BOUNDARY     = 12'd256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_quantum,
    input  logic [QUANTUM_WIDTH-1:0] quantum_in,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic                     instruction_commit,
    input  logic [11:0]              program_counter,
    input  logic                     jump_context_exchange,
    output logic [QUANTUM_WIDTH-1:0] output_watchdog,
    output logic                     context_exchange
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        REQUEST  = 2'd2
    } state_t;

    state_t                   state;
    logic [QUANTUM_WIDTH-1:0] quantum;
    logic [QUANTUM_WIDTH-1:0] count;
    logic [QUANTUM_WIDTH-1:0] arm_quantum;
    logic                     user_commit;

    // An arm in the same cycle as a load must see the freshly written value.
    assign arm_quantum = load_quantum ? quantum_in : quantum;
    assign user_commit = instruction_commit && (program_counter >= OS_BOUNDARY);

    assign output_watchdog = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            quantum          <= DEFAULT_QUANTUM;
            count            <= '0;
            context_exchange <= 1'b0;
        end else begin
            if (load_quantum) begin
                quantum <= quantum_in;
            end

            if (disarm) begin
                state            <= IDLE;
                count            <= '0;
                context_exchange <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            if (arm_quantum != '0) begin
                                count <= arm_quantum;
                                state <= COUNTING;
                            end else begin
                                count <= '0;
                            end
                        end
                    end

                    COUNTING: begin
                        if (arm) begin
                            // A zero quantum disables preemption, so it drops back to idle.
                            if (arm_quantum != '0) begin
                                count <= arm_quantum;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                            end
                        end else if (user_commit) begin
                            if (count == QUANTUM_WIDTH'(1)) begin
                                state            <= REQUEST;
                                context_exchange <= 1'b1;
                            end else begin
                                count <= count - QUANTUM_WIDTH'(1);
                            end
                        end
                    end

                    REQUEST: begin
                        // Count is held at 1 so the consumer's nonzero gate stays open.
                        if (jump_context_exchange) begin
                            context_exchange <= 1'b0;
`ifdef WATCHDOG_AUTO_REARM_EN
                            if (quantum != '0) begin
                                count <= quantum;
                                state <= COUNTING;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                            end
`else
                            count <= '0;
                            state <= IDLE;
`endif
                        end
                    end

                    default: begin
                        state            <= IDLE;
                        count            <= '0;
                        context_exchange <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_preemption_watchdog.sv
// Scoreboard bench for preemption_watchdog: directed test-plan sequences followed by random traffic,
// each cycle's expected outputs come from an abstract quantum/remaining/pending model.
module tb_preemption_watchdog;

    logic        clock;
    logic        reset;
    logic        load_quantum;
    logic [31:0] quantum_in;
    logic        arm;
    logic        disarm;
    logic        instruction_commit;
    logic [11:0] program_counter;
    logic        jump_context_exchange;
    logic [31:0] output_watchdog;
    logic        context_exchange;

    preemption_watchdog dut (
        .clock                 (clock),
        .reset                 (reset),
        .load_quantum          (load_quantum),
        .quantum_in            (quantum_in),
        .arm                   (arm),
        .disarm                (disarm),
        .instruction_commit    (instruction_commit),
        .program_counter       (program_counter),
        .jump_context_exchange (jump_context_exchange),
        .output_watchdog       (output_watchdog),
        .context_exchange      (context_exchange)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] wd;
        logic        cx;
    } expect_t;

    expect_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a quantum, the remaining instruction budget, and a pending-request flag.
    logic [31:0] m_quantum   = 32'd1000;
    logic [31:0] m_remaining = 32'd0;
    logic        m_pending   = 1'b0;

    task automatic model_update();
        logic [31:0] q_now;
        q_now = m_quantum;
        if (reset) begin
            m_quantum   = 32'd1000;
            m_remaining = 0;
            m_pending   = 0;
        end else begin
            if (disarm) begin
                m_remaining = 0;
                m_pending   = 0;
            end else if (m_pending) begin
                if (jump_context_exchange) begin
                    m_pending = 0;
`ifdef WATCHDOG_AUTO_REARM_EN
                    m_remaining = q_now;
`else
                    m_remaining = 0;
`endif
                end
            end else if (arm) begin
                m_remaining = load_quantum ? quantum_in : q_now;
            end else if (m_remaining > 0 && instruction_commit && program_counter >= 12'd256) begin
                if (m_remaining == 1) m_pending = 1;
                else m_remaining = m_remaining - 1;
            end
            if (load_quantum) m_quantum = quantum_in;
        end
    endtask

    task automatic clear_inputs();
        reset                 = 0;
        load_quantum          = 0;
        quantum_in            = 0;
        arm                   = 0;
        disarm                = 0;
        instruction_commit    = 0;
        program_counter       = 0;
        jump_context_exchange = 0;
    endtask

    // Inputs are changed at the falling edge; the model consumes them at the rising edge.
    task automatic tick();
        expect_t e;
        @(posedge clock);
        model_update();
        e.wd = m_remaining;
        e.cx = m_pending;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic commits(input int n, input logic [11:0] pc);
        for (int i = 0; i < n; i++) begin
            instruction_commit = 1;
            program_counter    = pc;
            tick();
        end
        instruction_commit = 0;
    endtask

    // Monitor: the DUT presents outputs every cycle; compare each against the queued expectation.
    always @(posedge clock) begin
        expect_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (output_watchdog !== e.wd) begin
                n_fail++;
                $display("FAIL output_watchdog at %0t: got %0d expected %0d", $time, output_watchdog, e.wd);
            end
            n_checks++;
            if (context_exchange !== e.cx) begin
                n_fail++;
                $display("FAIL context_exchange at %0t: got %0b expected %0b", $time, context_exchange, e.cx);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clock);
        tick();
        tick();
        reset = 0;
        tick();

        // Arm with the reset quantum.
        arm = 1; tick(); arm = 0; tick();

        // Load 3 together with arm, then count down to a request.
        load_quantum = 1; quantum_in = 3; arm = 1; tick(); clear_inputs();
        commits(3, 12'd300);
        commits(2, 12'd300);
        arm = 1; tick(); arm = 0;
        jump_context_exchange = 1; tick(); jump_context_exchange = 0;
        tick();
        jump_context_exchange = 1; tick(); jump_context_exchange = 0;

        // OS-region commits are not counted; the boundary address is.
        arm = 1; tick(); arm = 0;
        commits(1, 12'd100);
        commits(1, 12'd255);
        commits(1, 12'd256);
        commits(2, 12'd256);
        disarm = 1; jump_context_exchange = 1; tick(); clear_inputs();
        tick();

        // Reset while a request is pending.
        arm = 1; tick(); arm = 0;
        commits(3, 12'd4095);
        reset = 1; tick(); reset = 0;
        arm = 1; tick(); arm = 0; tick();

        // Zero quantum disables preemption.
        load_quantum = 1; quantum_in = 0; tick(); clear_inputs();
        arm = 1; tick(); arm = 0;
        commits(50, 12'd400);

        // Random traffic.
        load_quantum = 1; quantum_in = 4; arm = 1; tick(); clear_inputs();
        for (int i = 0; i < 3000; i++) begin
            reset                 = ($urandom_range(0, 299) == 0);
            load_quantum          = ($urandom_range(0, 14) == 0);
            quantum_in            = $urandom_range(1, 6);
            arm                   = ($urandom_range(0, 19) == 0);
            disarm                = ($urandom_range(0, 59) == 0);
            jump_context_exchange = ($urandom_range(0, 3) == 0);
            instruction_commit    = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       program_counter = 12'd255;
                1:       program_counter = 12'd256;
                default: program_counter = 12'($urandom_range(0, 4095));
            endcase
            tick();
        end
        clear_inputs();
        tick();
        tick();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
